skey_rom_ctrl: RTL and testbench

Parametrised secret-key ROM with a gated random-access read port and a slot-streaming read port. The streaming port feeds the attestation HMAC datapath one key word per cycle under a valid/ready handshake. Sits beside the program memory and is clocked by mclk. Holds NSLOTS independent keys of KEY_WORDS words each in one block ROM.

---
 rtl/skey_rom_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_skey_rom_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skey_rom_ctrl.sv
// Secret-key ROM: gated random-access read port plus a per-slot streaming port with valid/ready.
// Optional read-lock feature enabled by defining SKEY_RD_LOCK_EN.
module skey_rom_ctrl #(
  parameter int DW        = 16,
  parameter int NSLOTS    = 2,
  parameter int KEY_WORDS = 32,
  parameter int AW        = $clog2(NSLOTS * KEY_WORDS),
  parameter int SW        = (NSLOTS > 1) ? $clog2(NSLOTS) : 1
) (
  input  logic          mclk,
  input  logic          puc_rst,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_cen,
  input  logic          rd_lock,
  output logic [DW-1:0] rd_dout,
  output logic          rd_err,
  input  logic          strm_start,
  input  logic [SW-1:0] strm_slot,
  input  logic          strm_abort,
  output logic [DW-1:0] strm_data,
  output logic          strm_valid,
  output logic          strm_last,
  input  logic          strm_ready,
  output logic          strm_busy,
  output logic          strm_err
);

  localparam int DEPTH    = NSLOTS * KEY_WORDS;
  localparam int ROM_SIZE = 1 << AW;
  localparam int IW       = $clog2(KEY_WORDS);
  localparam logic [IW-1:0] IDX_LAST = IW'(KEY_WORDS - 1);

  // Sized to the full address space so every index is legal; entries past DEPTH are never reachable.
  logic [DW-1:0] rom [ROM_SIZE];

  generate
    for (genvar gi = 0; gi < ROM_SIZE; gi++) begin : g_rom
      localparam logic [63:0] WORD = (gi < DEPTH) ? (64'(gi) * 64'h1234) : 64'd0;
      assign rom[gi] = WORD[DW-1:0];
    end
  endgenerate

  logic locked;

`ifdef SKEY_RD_LOCK_EN
  logic lock_reg;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst)
      lock_reg <= 1'b0;
    else if (rd_lock)
      lock_reg <= 1'b1;
  end

  assign locked = lock_reg;
`else
  logic unused_rd_lock;
  assign unused_rd_lock = rd_lock;
  assign locked         = 1'b0;
`endif

  logic rd_ok;
  assign rd_ok = ({1'b0, rd_addr} < (AW + 1)'(DEPTH)) && !locked;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      rd_dout <= '0;
      rd_err  <= 1'b0;
    end else begin
      rd_err <= 1'b0;
      if (!rd_cen) begin
        if (rd_ok) begin
          rd_dout <= rom[rd_addr];
        end else begin
          rd_dout <= '0;
          rd_err  <= 1'b1;
        end
      end
    end
  end

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [AW-1:0] base_reg, base_next;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] data_reg, data_next;
  logic          valid_reg, valid_next;
  logic          last_reg, last_next;
  logic          busy_reg, busy_next;
  logic          err_reg, err_next;
  logic          slot_ok;

  assign slot_ok = ({1'b0, strm_slot} < (SW + 1)'(NSLOTS));

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    base_next  = base_reg;
    rom_addr   = base_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    busy_next  = busy_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Start outranks a simultaneous abort here; abort alone is a no-op.
        if (strm_start) begin
          if (slot_ok) begin
            base_next  = AW'(strm_slot) * AW'(KEY_WORDS);
            idx_next   = '0;
            busy_next  = 1'b1;
            state_next = FETCH;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      FETCH: begin
        if (strm_abort) begin
          state_next = IDLE;
          valid_next = 1'b0;
          last_next  = 1'b0;
          busy_next  = 1'b0;
        end else begin
          data_next  = rom[rom_addr];
          valid_next = 1'b1;
          last_next  = 1'b0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (strm_abort) begin
          state_next = IDLE;
          valid_next = 1'b0;
          last_next  = 1'b0;
          busy_next  = 1'b0;
        end else if (strm_ready) begin
          if (idx_reg == IDX_LAST) begin
            state_next = IDLE;
            valid_next = 1'b0;
            last_next  = 1'b0;
            busy_next  = 1'b0;
          end else begin
            idx_next  = idx_reg + IW'(1);
            rom_addr  = base_reg + AW'(idx_reg) + AW'(1);
            data_next = rom[rom_addr];
            last_next = (idx_next == IDX_LAST);
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      base_reg  <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      base_reg  <= base_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  assign strm_data  = data_reg;
  assign strm_valid = valid_reg;
  assign strm_last  = last_reg;
  assign strm_busy  = busy_reg;
  assign strm_err   = err_reg;

endmodule

// File: tb/tb_skey_rom_ctrl.sv
// Randomized self-checking bench for skey_rom_ctrl against a word-level model of both ports.
// Widened AW/SW so out-of-range addresses and slot indices are representable.
module tb_skey_rom_ctrl;

  localparam int DW     = 16;
  localparam int NSLOTS = 2;
  localparam int KW     = 32;
  localparam int AW     = 7;
  localparam int SW     = 2;
  localparam int DEPTH  = NSLOTS * KW;
`ifdef SKEY_RD_LOCK_EN
  localparam bit LOCK_BUILD = 1'b1;
`else
  localparam bit LOCK_BUILD = 1'b0;
`endif

  logic          mclk;
  logic          puc_rst;
  logic [AW-1:0] rd_addr;
  logic          rd_cen;
  logic          rd_lock;
  logic [DW-1:0] rd_dout;
  logic          rd_err;
  logic          strm_start;
  logic [SW-1:0] strm_slot;
  logic          strm_abort;
  logic [DW-1:0] strm_data;
  logic          strm_valid;
  logic          strm_last;
  logic          strm_ready;
  logic          strm_busy;
  logic          strm_err;

  skey_rom_ctrl #(.DW(DW), .NSLOTS(NSLOTS), .KEY_WORDS(KW), .AW(AW), .SW(SW)) dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .rd_addr(rd_addr), .rd_cen(rd_cen), .rd_lock(rd_lock),
    .rd_dout(rd_dout), .rd_err(rd_err),
    .strm_start(strm_start), .strm_slot(strm_slot), .strm_abort(strm_abort),
    .strm_data(strm_data), .strm_valid(strm_valid), .strm_last(strm_last),
    .strm_ready(strm_ready), .strm_busy(strm_busy), .strm_err(strm_err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [DW-1:0] exp_dout;
  bit            locked_m;
  int            strm_base;
  int            strm_k;

  function automatic logic [DW-1:0] key_word(input int i);
    logic [63:0] p;
    p = 64'(i) * 64'h1234;
    return p[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: predict both ports from current inputs, advance, then compare.
  task automatic step();
    bit   hs;
    logic exp_err;
    hs      = strm_valid && strm_ready && !strm_abort;
    exp_err = 1'b0;
    if (!rd_cen) begin
      if (int'(rd_addr) < DEPTH && !locked_m) begin
        exp_dout = key_word(int'(rd_addr));
      end else begin
        exp_dout = '0;
        exp_err  = 1'b1;
      end
    end
    if (LOCK_BUILD && rd_lock) locked_m = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    if (hs) strm_k++;
    check("rd_dout", rd_dout, exp_dout);
    check("rd_err", rd_err, exp_err);
    if (strm_valid) begin
      check("strm_data", strm_data, key_word(strm_base + strm_k));
      check("strm_last", strm_last, strm_k == KW - 1);
    end
  endtask

  task automatic rand_read();
    rd_cen  = 1'($urandom_range(0, 1));
    rd_addr = AW'($urandom_range(0, 127));
    rd_lock = LOCK_BUILD ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready plus starts while busy
  // kill: 0 none, 1 abort when kill_at words accepted, 2 async reset at that point
  task automatic run_stream(input int slot, input int mode, input int kill, input int kill_at);
    int cyc;
    bit pat [4];
    bit tried_start;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    strm_slot  = SW'(slot);
    strm_start = 1'b1;
    strm_ready = 1'b0;
    step();
    strm_start = 1'b0;
    strm_base  = slot * KW;
    strm_k     = 0;
    check("start_busy", strm_busy, 1'b1);
    check("start_valid", strm_valid, 1'b0);
    step();
    check("valid_2edges", strm_valid, 1'b1);
    cyc = 0;
    while (strm_valid && cyc < 200) begin
      cyc++;
      rand_read();
      case (mode)
        0:       strm_ready = 1'b1;
        1:       strm_ready = pat[cyc % 4];
        default: strm_ready = 1'($urandom_range(0, 1));
      endcase
      tried_start = (mode == 2) && ($urandom_range(0, 3) == 0);
      if (tried_start) begin
        strm_start = 1'b1;
        strm_slot  = SW'($urandom_range(0, 3));
      end
      if (kill == 2 && strm_k == kill_at) begin
        puc_rst = 1'b1;
        #1;
        check("rst_valid", strm_valid, 1'b0);
        check("rst_busy", strm_busy, 1'b0);
        check("rst_data", strm_data, 0);
        check("rst_dout", rd_dout, 0);
        exp_dout = '0;
        locked_m = 1'b0;
        @(negedge mclk);
        puc_rst = 1'b0;
        strm_ready = 1'b0;
        return;
      end
      if (kill == 1 && strm_k == kill_at) strm_abort = 1'b1;
      step();
      strm_start = 1'b0;
      if (tried_start) check("start_while_busy_err", strm_err, 1'b0);
      if (strm_abort) begin
        strm_abort = 1'b0;
        check("abort_valid", strm_valid, 1'b0);
        check("abort_busy", strm_busy, 1'b0);
        check("abort_words", strm_k, kill_at);
        strm_ready = 1'b0;
        return;
      end
    end
    check("stream_no_timeout", cyc < 200, 1'b1);
    check("stream_words", strm_k, KW);
    check("stream_busy_drop", strm_busy, 1'b0);
    strm_ready = 1'b0;
  endtask

  initial begin
    puc_rst    = 1'b1;
    rd_addr    = '0;
    rd_cen     = 1'b1;
    rd_lock    = 1'b0;
    strm_start = 1'b0;
    strm_slot  = '0;
    strm_abort = 1'b0;
    strm_ready = 1'b0;
    exp_dout   = '0;
    locked_m   = 1'b0;
    strm_base  = 0;
    strm_k     = 0;
    #12;
    check("reset_rd_dout", rd_dout, 0);
    check("reset_rd_err", rd_err, 0);
    check("reset_strm_data", strm_data, 0);
    check("reset_strm_valid", strm_valid, 0);
    check("reset_strm_last", strm_last, 0);
    check("reset_strm_busy", strm_busy, 0);
    check("reset_strm_err", strm_err, 0);
    @(negedge mclk);
    puc_rst = 1'b0;

    rd_cen = 1'b0; rd_addr = 7'd5;
    step();
    check("read_addr5", rd_dout, 16'h5B04);
    rd_addr = 7'd3;
    step();
    check("read_addr3", rd_dout, 16'h369C);
    rd_addr = 7'd64;
    step();
    check("read_oob_dout", rd_dout, 0);
    check("read_oob_err", rd_err, 1'b1);
    rd_cen = 1'b1;
    step();
    check("read_oob_err_pulse", rd_err, 1'b0);

    strm_slot = 2'd2; strm_start = 1'b1;
    step();
    check("bad_slot_err", strm_err, 1'b1);
    check("bad_slot_busy", strm_busy, 1'b0);
    strm_start = 1'b0;
    step();
    check("bad_slot_err_pulse", strm_err, 1'b0);

    run_stream(1, 0, 0, 0);
    check("slot1_last_word", strm_data, 16'h7ACC);
    run_stream(0, 1, 0, 0);
    run_stream(1, 0, 1, 3);
    run_stream(0, 0, 0, 0);
    run_stream(1, 2, 0, 0);
    run_stream(0, 2, 0, 0);
    run_stream(1, 1, 2, 5);

    // start beats abort in IDLE, then abort lands in FETCH
    rd_cen = 1'b1;
    strm_slot = 2'd0; strm_start = 1'b1; strm_abort = 1'b1;
    step();
    check("start_over_abort", strm_busy, 1'b1);
    strm_start = 1'b0;
    step();
    check("abort_fetch_busy", strm_busy, 1'b0);
    check("abort_fetch_valid", strm_valid, 1'b0);
    step();
    check("abort_idle_busy", strm_busy, 1'b0);
    check("abort_idle_err", strm_err, 1'b0);
    strm_abort = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rand_read();
      step();
    end

`ifdef SKEY_RD_LOCK_EN
    rd_cen = 1'b0; rd_addr = 7'd3; rd_lock = 1'b0;
    step();
    check("lock_pre_read", rd_dout, 16'h369C);
    rd_cen = 1'b1; rd_lock = 1'b1;
    step();
    rd_lock = 1'b0; rd_cen = 1'b0; rd_addr = 7'd3;
    step();
    check("locked_dout", rd_dout, 0);
    check("locked_err", rd_err, 1'b1);
    run_stream(0, 1, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
